// File: rtl/mem_arb_pkg.sv
// Shared constants for the two-port memory arbiter: FSM state encoding and grant IDs.
package mem_arb_pkg;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_ACCESS = 2'd1;
  localparam logic [1:0] ST_RESP   = 2'd2;

  localparam logic GNT_A = 1'b0;
  localparam logic GNT_B = 1'b1;

endpackage

// File: rtl/mem_arb_select.sv
// Winner select between the fetch (A) and load/store (B) requesters.
// B normally wins; A is forced through after B_MAX_RUN back-to-back B grants.
module mem_arb_select
  import mem_arb_pkg::*;
#(
  parameter int B_MAX_RUN = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic arb_en,
  input  logic req_a,
  input  logic req_b,
  output logic win
);

  localparam int RUN_W = $clog2(B_MAX_RUN + 1);

  logic [RUN_W-1:0] run;
  logic             a_starved;

  assign a_starved = req_a && (run == RUN_W'(B_MAX_RUN));

  // NOTE: assign a default before any branch so a combinational block never infers a latch.
  always_comb begin
    win = GNT_A;
    if (req_b && !a_starved) win = GNT_B;
  end

  // NOTE: state updates use non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      run <= '0;
    end else if (arb_en) begin
      if (!req_a || win == GNT_A) run <= '0;
      else if (req_b && run != RUN_W'(B_MAX_RUN)) run <= run + RUN_W'(1);
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-port synchronous RAM between instruction fetch (A) and load/store (B),
// one transaction at a time, with a one-cycle dready pulse per completed transaction.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W    = 7,
  parameter int DATA_W    = 32,
  parameter int RD_LAT    = 2,
  parameter int B_MAX_RUN = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                rea,
  input  logic [DATA_W/8-1:0] wea,
  input  logic [ADDR_W-1:0]   addra,
  input  logic [DATA_W-1:0]   dina,
  output logic [DATA_W-1:0]   douta,
  output logic                dreadya,
  input  logic                reb,
  input  logic [DATA_W/8-1:0] web,
  input  logic [ADDR_W-1:0]   addrb,
  input  logic [DATA_W-1:0]   dinb,
  output logic [DATA_W-1:0]   doutb,
  output logic                dreadyb,
  output logic                mem_en,
  output logic [DATA_W/8-1:0] mem_we,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_din,
  input  logic [DATA_W-1:0]   mem_dout
);

  localparam int BE_W  = DATA_W / 8;
  localparam int CNT_W = $clog2(RD_LAT + 1);

  logic [1:0]        state;
  logic              gnt;
  logic              is_wr;
  logic [ADDR_W-1:0] addr_q;
  logic [BE_W-1:0]   we_q;
  logic [DATA_W-1:0] din_q;
  logic [CNT_W-1:0]  cnt;
  logic              req_a, req_b, win;

  assign req_a = rea | (|wea);
  assign req_b = reb | (|web);

  mem_arb_select #(.B_MAX_RUN(B_MAX_RUN)) u_select (
    .clk    (clk),
    .rst    (rst),
    .arb_en (state == ST_IDLE),
    .req_a  (req_a),
    .req_b  (req_b),
    .win    (win)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= ST_IDLE;
      gnt    <= GNT_A;
      is_wr  <= 1'b0;
      addr_q <= '0;
      we_q   <= '0;
      din_q  <= '0;
      cnt    <= '0;
      douta  <= '0;
      doutb  <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (req_a || req_b) begin
            gnt <= win;
            cnt <= '0;
            state <= ST_ACCESS;
            if (win == GNT_B) begin
              addr_q <= addrb;
              we_q   <= web;
              din_q  <= dinb;
              is_wr  <= |web;
            end else begin
              addr_q <= addra;
              we_q   <= wea;
              din_q  <= dina;
              is_wr  <= |wea;
            end
          end
        end
        ST_ACCESS: begin
          if (is_wr) begin
            state <= ST_RESP;
          end else begin
            cnt <= cnt + CNT_W'(1);
            // Read data is valid on the last latency cycle; only the granted port captures it.
            if (cnt == CNT_W'(RD_LAT - 1)) begin
              if (gnt == GNT_B) doutb <= mem_dout;
              else              douta <= mem_dout;
              state <= ST_RESP;
            end
          end
        end
        ST_RESP: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

  always_comb begin
    mem_en   = 1'b0;
    mem_we   = '0;
    mem_addr = '0;
    mem_din  = '0;
    dreadya  = 1'b0;
    dreadyb  = 1'b0;
    if (state == ST_ACCESS) begin
      mem_en   = 1'b1;
      mem_addr = addr_q;
      mem_din  = din_q;
      mem_we   = is_wr ? we_q : '0;
    end else if (state == ST_RESP) begin
      dreadya = (gnt == GNT_A);
      dreadyb = (gnt == GNT_B);
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with a behavioural byte-writable RAM
// (one registered read stage) and immediate-assertion checks.
module tb_mem_port_arbiter;
  import mem_arb_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        rea, reb;
  logic [3:0]  wea, web;
  logic [6:0]  addra, addrb;
  logic [31:0] dina, dinb;
  logic [31:0] douta, doutb;
  logic        dreadya, dreadyb;
  logic        mem_en;
  logic [3:0]  mem_we;
  logic [6:0]  mem_addr;
  logic [31:0] mem_din, mem_dout;

  logic [31:0] mem [128];
  logic [31:0] rd_q;
  logic        ld_en;
  logic [6:0]  ld_addr;
  logic [31:0] ld_data;

  int vectors = 0;
  int errors  = 0;

  always #5 clk = ~clk;

  mem_port_arbiter #(.ADDR_W(7), .DATA_W(32), .RD_LAT(2), .B_MAX_RUN(4)) dut (
    .clk(clk), .rst(rst),
    .rea(rea), .wea(wea), .addra(addra), .dina(dina), .douta(douta), .dreadya(dreadya),
    .reb(reb), .web(web), .addrb(addrb), .dinb(dinb), .doutb(doutb), .dreadyb(dreadyb),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_din(mem_din),
    .mem_dout(mem_dout)
  );

  // RAM model: bench preload port takes precedence, otherwise the DUT drives it.
  always @(posedge clk) begin
    if (ld_en) begin
      mem[ld_addr] <= ld_data;
    end else if (mem_en) begin
      for (int i = 0; i < 4; i++)
        if (mem_we[i]) mem[mem_addr][8*i +: 8] <= mem_din[8*i +: 8];
      rd_q <= mem[mem_addr];
    end
  end
  assign mem_dout = rd_q;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input logic [6:0] a, input logic [31:0] d);
    ld_en = 1'b1; ld_addr = a; ld_data = d;
    tick();
    ld_en = 1'b0;
  endtask

  // Waits for the chosen port's dready, returning the number of edges taken.
  task automatic wait_ready(input logic is_b, input string tag, output int cycles);
    cycles = 0;
    while (!(is_b ? dreadyb : dreadya) && cycles < 50) begin
      tick();
      cycles++;
    end
    check({tag, "_seen"}, {31'd0, is_b ? dreadyb : dreadya}, 32'd1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int   cyc, n, since_a, max_gap;
    logic exp_gnt [10];

    rst = 1'b1; rea = 0; reb = 0; wea = 0; web = 0;
    addra = 0; addrb = 0; dina = 0; dinb = 0;
    ld_en = 0; ld_addr = 0; ld_data = 0;
    tick(); tick();
    check("rst_state", {30'd0, dut.state}, {30'd0, ST_IDLE});
    check("rst_outs", {douta | doutb}, 32'd0);
    check("rst_ctl", {26'd0, mem_en, mem_we, dreadya}, 32'd0);
    check("rst_addr", {25'd0, mem_addr}, 32'd0);
    rst = 1'b0;

    // 1: A read of address 5
    load(7'd5, 32'hDEADBEEF);
    rea = 1; addra = 7'd5;
    tick();
    check("t1_en_k1", {31'd0, mem_en}, 32'd1);
    check("t1_addr_k1", {25'd0, mem_addr}, 32'd5);
    check("t1_rdy_k1", {31'd0, dreadya}, 32'd0);
    tick();
    check("t1_addr_k2", {25'd0, mem_addr}, 32'd5);
    check("t1_we_k2", {28'd0, mem_we}, 32'd0);
    check("t1_rdy_k2", {31'd0, dreadya}, 32'd0);
    tick();
    check("t1_rdy_k3", {31'd0, dreadya}, 32'd1);
    check("t1_douta_k3", douta, 32'hDEADBEEF);
    check("t1_en_k3", {31'd0, mem_en}, 32'd0);
    rea = 0;
    tick();
    check("t1_rdy_k4", {31'd0, dreadya}, 32'd0);
    check("t1_douta_hold", douta, 32'hDEADBEEF);

    // 2: B partial byte write
    load(7'd10, 32'hFFFFFFFF);
    web = 4'b0011; addrb = 7'd10; dinb = 32'h12345678;
    tick();
    check("t2_we_k1", {28'd0, mem_we}, 32'h3);
    check("t2_addr_k1", {25'd0, mem_addr}, 32'd10);
    tick();
    check("t2_we_k2", {28'd0, mem_we}, 32'h0);
    check("t2_rdyb_k2", {31'd0, dreadyb}, 32'd1);
    check("t2_mem10", mem[10], 32'hFFFF5678);
    web = 0;
    tick();
    check("t2_rdyb_k3", {31'd0, dreadyb}, 32'd0);
    check("t2_doutb", doutb, 32'd0);
    check("t2_douta", douta, 32'hDEADBEEF);

    // 3: simultaneous requests, B first then A four cycles later
    load(7'd1, 32'h11111111);
    load(7'd2, 32'h22222222);
    rea = 1; addra = 7'd1; reb = 1; addrb = 7'd2;
    wait_ready(1'b1, "t3_b", cyc);
    check("t3_b_lat", cyc, 32'd3);
    check("t3_no_a", {31'd0, dreadya}, 32'd0);
    check("t3_doutb", doutb, 32'h22222222);
    reb = 0;
    wait_ready(1'b0, "t3_a", cyc);
    check("t3_a_gap", cyc, 32'd4);
    check("t3_douta", douta, 32'h11111111);
    check("t3_doutb_hold", doutb, 32'h22222222);
    rea = 0;
    tick();

    // 4: both held, starvation limit forces A every fifth grant
    exp_gnt = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    rea = 1; reb = 1;
    n = 0; cyc = 0; since_a = 0; max_gap = 0;
    while (n < 10 && cyc < 200) begin
      tick();
      cyc++;
      if (dreadya || dreadyb) begin
        check($sformatf("t4_gnt%0d", n), {31'd0, dreadyb}, {31'd0, exp_gnt[n]});
        if (dreadya) since_a = 0;
        else         since_a++;
        if (since_a > max_gap) max_gap = since_a;
        n++;
      end
    end
    check("t4_count", n, 32'd10);
    check("t4_max_b_run", max_gap, 32'd4);
    rea = 0; reb = 0;
    tick();

    // 5: reset during a write ACCESS aborts it
    load(7'd3, 32'h55555555);
    web = 4'b1111; addrb = 7'd3; dinb = 32'hCAFEF00D;
    tick();
    check("t5_we_access", {28'd0, mem_we}, 32'hF);
    rst = 1; web = 0;
    tick();
    rst = 0;
    check("t5_we_after", {28'd0, mem_we}, 32'h0);
    check("t5_state", {30'd0, dut.state}, {30'd0, ST_IDLE});
    check("t5_doutb", doutb, 32'd0);
    n = 0;
    for (int i = 0; i < 4; i++) begin
      if (dreadyb || dreadya) n++;
      tick();
    end
    check("t5_no_rdy", n, 32'd0);

    // request dropped during ACCESS still completes, at the top address
    web = 4'b1111; addrb = 7'h7F; dinb = 32'h0BADCAFE;
    tick();
    web = 0;
    check("drop_addr", {25'd0, mem_addr}, 32'h7F);
    tick();
    check("drop_rdyb", {31'd0, dreadyb}, 32'd1);
    check("drop_mem7f", mem[127], 32'h0BADCAFE);
    tick();
    rea = 1; addra = 7'h7F;
    wait_ready(1'b0, "rd7f", cyc);
    check("rd7f_douta", douta, 32'h0BADCAFE);
    rea = 0;
    tick();

    // 6: re with we set is a write
    addra = 7'd5; rea = 1;
    wait_ready(1'b0, "t6_pre", cyc);
    rea = 0;
    tick();
    load(7'd7, 32'h11223344);
    rea = 1; wea = 4'b0001; dina = 32'h000000AA; addra = 7'd7;
    tick();
    check("t6_we", {28'd0, mem_we}, 32'h1);
    tick();
    check("t6_rdya", {31'd0, dreadya}, 32'd1);
    check("t6_mem7", mem[7], 32'h112233AA);
    check("t6_douta", douta, 32'hDEADBEEF);
    rea = 0; wea = 0;
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
